// File: rtl/inst_fetch_queue_if.sv
// Fetch-side push bus and decode-side issue/output bus of the instruction fetch queue.
// The queue takes the slave modport; the fetch/decode environment takes the master modport.
interface inst_fetch_queue_if;
    logic        flush;
    logic        in_valid0;
    logic        in_valid1;
    logic [31:0] in_pc0;
    logic [31:0] in_inst0;
    logic        in_adel0;
    logic [31:0] in_pc1;
    logic [31:0] in_inst1;
    logic        in_adel1;
    logic        almost_full;
    logic        empty;
    logic        issue0;
    logic        issue1;
    logic        out_valid0;
    logic [31:0] out_pc0;
    logic [31:0] out_inst0;
    logic        out_adel0;
    logic        out_valid1;
    logic [31:0] out_pc1;
    logic [31:0] out_inst1;
    logic        out_adel1;

    modport master (
        output flush, in_valid0, in_valid1, in_pc0, in_inst0, in_adel0,
               in_pc1, in_inst1, in_adel1, issue0, issue1,
        input  almost_full, empty, out_valid0, out_pc0, out_inst0, out_adel0,
               out_valid1, out_pc1, out_inst1, out_adel1
    );

    modport slave (
        input  flush, in_valid0, in_valid1, in_pc0, in_inst0, in_adel0,
               in_pc1, in_inst1, in_adel1, issue0, issue1,
        output almost_full, empty, out_valid0, out_pc0, out_inst0, out_adel0,
               out_valid1, out_pc1, out_inst1, out_adel1
    );
endinterface

// File: rtl/inst_fetch_queue.sv
// Dual-wide instruction queue between icache return and the two ID decoder slots.
// Pushes and retires 0/1/2 entries per cycle; flush empties it at the next edge.
module inst_fetch_queue #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input logic               clk,
    input logic               resetn,
    inst_fetch_queue_if.slave fq
);
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adel;
    } entry_t;

    localparam logic [ADDR_W:0] AF_LIMIT = (ADDR_W+1)'(DEPTH - 2);
    localparam logic [ADDR_W:0] TWO      = (ADDR_W+1)'(2);

    entry_t            storage [DEPTH];
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr1;
    logic [ADDR_W-1:0] wr_ptr1;
    logic [ADDR_W:0]   count;
    logic [ADDR_W:0]   count_next;
    logic [1:0]        npush;
    logic [1:0]        npop;
    entry_t            rd0;
    entry_t            rd1;

    assign rd_ptr1 = rd_ptr + ADDR_W'(1);
    assign wr_ptr1 = wr_ptr + ADDR_W'(1);

    // Status and read path depend only on registered state, so a push is never bypassed to the outputs.
    assign fq.almost_full = (count > AF_LIMIT);
    assign fq.empty       = (count == '0);
    assign fq.out_valid0  = (count != '0);
    assign fq.out_valid1  = (count >= TWO);

    assign rd0 = storage[rd_ptr];
    assign rd1 = storage[rd_ptr1];

    assign fq.out_pc0   = fq.out_valid0 ? rd0.pc   : '0;
    assign fq.out_inst0 = fq.out_valid0 ? rd0.inst : '0;
    assign fq.out_adel0 = fq.out_valid0 ? rd0.adel : 1'b0;
    assign fq.out_pc1   = fq.out_valid1 ? rd1.pc   : '0;
    assign fq.out_inst1 = fq.out_valid1 ? rd1.inst : '0;
    assign fq.out_adel1 = fq.out_valid1 ? rd1.adel : 1'b0;

    always_comb begin
        npush = 2'd0;
        if (!fq.flush && fq.in_valid0 && !fq.almost_full)
            npush = fq.in_valid1 ? 2'd2 : 2'd1;
    end

    always_comb begin
        npop = 2'd0;
        if (!fq.flush && fq.issue0 && fq.out_valid0)
            npop = (fq.issue1 && fq.out_valid1) ? 2'd2 : 2'd1;
    end

    assign count_next = count + {{(ADDR_W-1){1'b0}}, npush} - {{(ADDR_W-1){1'b0}}, npop};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (fq.flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr + ADDR_W'(npop);
            wr_ptr <= wr_ptr + ADDR_W'(npush);
            count  <= count_next;
        end
    end

    // Storage carries no reset; stale contents are hidden by the output masking above.
    always_ff @(posedge clk) begin
        if (npush != 2'd0)
            storage[wr_ptr] <= '{pc: fq.in_pc0, inst: fq.in_inst0, adel: fq.in_adel0};
        if (npush == 2'd2)
            storage[wr_ptr1] <= '{pc: fq.in_pc1, inst: fq.in_inst1, adel: fq.in_adel1};
    end
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue: a reference queue in the monitor checks every cycle,
// plus hand-computed point checks after key transactions.
`timescale 1ns/1ps
module tb_inst_fetch_queue;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   errors = 0;
    int   checks = 0;

    inst_fetch_queue_if bus();

    inst_fetch_queue #(.DEPTH(DEPTH), .ADDR_W(4)) dut (
        .clk    (clk),
        .resetn (resetn),
        .fq     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: entries are {pc, inst, adel}
    logic [64:0] mq[$];
    int unsigned n;
    logic        af_m;
    logic [65:0] exp0, exp1;

    always @(negedge resetn) mq.delete();

    always @(negedge clk) begin
        n    = mq.size();
        exp0 = (n >= 1) ? {1'b1, mq[0]} : '0;
        exp1 = (n >= 2) ? {1'b1, mq[1]} : '0;
        check("mon_slot0", {bus.out_valid0, bus.out_pc0, bus.out_inst0, bus.out_adel0}, exp0);
        check("mon_slot1", {bus.out_valid1, bus.out_pc1, bus.out_inst1, bus.out_adel1}, exp1);
        check("mon_flags", {64'd0, bus.empty, bus.almost_full}, {64'd0, n == 0, n > DEPTH - 2});
        if (resetn) begin
            if (bus.flush) mq.delete();
            else begin
                af_m = (n > DEPTH - 2);
                if (bus.issue0 && n >= 1) begin
                    void'(mq.pop_front());
                    if (bus.issue1 && n >= 2) void'(mq.pop_front());
                end
                if (bus.in_valid0 && !af_m) begin
                    mq.push_back({bus.in_pc0, bus.in_inst0, bus.in_adel0});
                    if (bus.in_valid1) mq.push_back({bus.in_pc1, bus.in_inst1, bus.in_adel1});
                end
            end
        end
    end

    task automatic idle();
        bus.flush = 0; bus.in_valid0 = 0; bus.in_valid1 = 0;
        bus.in_pc0 = '0; bus.in_inst0 = '0; bus.in_adel0 = 0;
        bus.in_pc1 = '0; bus.in_inst1 = '0; bus.in_adel1 = 0;
        bus.issue0 = 0; bus.issue1 = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push1(input logic [31:0] pc, input logic [31:0] inst, input logic adel);
        bus.in_valid0 = 1; bus.in_valid1 = 0;
        bus.in_pc0 = pc; bus.in_inst0 = inst; bus.in_adel0 = adel;
    endtask

    task automatic push2(input logic [31:0] pc0, input logic [31:0] inst0,
                         input logic [31:0] pc1, input logic [31:0] inst1, input logic adel1);
        bus.in_valid0 = 1; bus.in_valid1 = 1;
        bus.in_pc0 = pc0; bus.in_inst0 = inst0; bus.in_adel0 = 0;
        bus.in_pc1 = pc1; bus.in_inst1 = inst1; bus.in_adel1 = adel1;
    endtask

    int unsigned seq = 0;
    task automatic push2_seq();
        push2(32'h0000_1000 + seq * 4, 32'hA000_0000 + seq,
              32'h0000_1004 + seq * 4, 32'hA000_0001 + seq, seq[2]);
        seq += 2;
    endtask

    initial begin
        idle();
        #12;
        check("reset_empty", {65'd0, bus.empty}, {65'd0, 1'b1});
        resetn = 1;
        tick();

        // single push, visible next cycle
        idle(); push1(32'hBFC0_0000, 32'h2402_0001, 0); tick();
        check("single_slot0", {bus.out_valid0, bus.out_pc0, bus.out_inst0, bus.out_adel0},
              {1'b1, 32'hBFC0_0000, 32'h2402_0001, 1'b0});
        check("single_v1_empty", {64'd0, bus.out_valid1, bus.empty}, 66'd0);
        idle(); bus.issue0 = 1; tick();
        check("single_drained", {65'd0, bus.empty}, {65'd0, 1'b1});

        // dual push then dual issue
        idle(); push2(32'hBFC0_0000, 32'h3C01_1234, 32'hBFC0_0004, 32'h3421_0001, 0); tick();
        check("dual_slot0", {bus.out_valid0, bus.out_pc0, bus.out_inst0, bus.out_adel0},
              {1'b1, 32'hBFC0_0000, 32'h3C01_1234, 1'b0});
        check("dual_slot1", {bus.out_valid1, bus.out_pc1, bus.out_inst1, bus.out_adel1},
              {1'b1, 32'hBFC0_0004, 32'h3421_0001, 1'b0});
        idle(); bus.issue0 = 1; bus.issue1 = 1; tick();
        check("dual_out0_zero", {bus.out_valid0, bus.out_pc0, bus.out_inst0, bus.out_adel0}, 66'd0);
        check("dual_out1_zero", {bus.out_valid1, bus.out_pc1, bus.out_inst1, bus.out_adel1}, 66'd0);

        // fill to 15, a further dual push is dropped
        for (int i = 0; i < 7; i++) begin idle(); push2_seq(); tick(); end
        check("fill14_af", {65'd0, bus.almost_full}, 66'd0);
        idle(); push1(32'h0000_2000, 32'hC0DE_0000, 1); tick();
        check("fill15_af", {65'd0, bus.almost_full}, {65'd0, 1'b1});
        idle(); push2(32'hDEAD_0000, 32'hDEAD_0001, 32'hDEAD_0004, 32'hDEAD_0005, 0); tick();
        check("fill_drop_af", {64'd0, bus.almost_full, bus.out_valid1}, {64'd0, 2'b11});
        for (int i = 0; i < 10; i++) begin idle(); bus.issue0 = 1; bus.issue1 = 1; tick(); end
        check("fill_drained", {65'd0, bus.empty}, {65'd0, 1'b1});

        // wrap: flush, advance pointers to 15, dual push straddling 15 -> 0
        idle(); bus.flush = 1; tick();
        idle(); push1(32'h0000_3000, 32'h1111_0000, 0); tick();
        for (int i = 1; i < 15; i++) begin
            idle(); push1(32'h0000_3000 + i * 4, 32'h1111_0000 + i, 0); bus.issue0 = 1; tick();
        end
        idle(); bus.issue0 = 1; tick();
        idle(); push2(32'hA000_0000, 32'h2222_0000, 32'hA000_0004, 32'h2222_0001, 1); tick();
        check("wrap_slot0", {bus.out_valid0, bus.out_pc0, bus.out_inst0, bus.out_adel0},
              {1'b1, 32'hA000_0000, 32'h2222_0000, 1'b0});
        check("wrap_slot1", {bus.out_valid1, bus.out_pc1, bus.out_inst1, bus.out_adel1},
              {1'b1, 32'hA000_0004, 32'h2222_0001, 1'b1});
        idle(); bus.issue0 = 1; bus.issue1 = 1; tick();
        check("wrap_drained", {65'd0, bus.empty}, {65'd0, 1'b1});

        // simultaneous dual push + dual issue at count 14
        for (int i = 0; i < 7; i++) begin idle(); push2_seq(); tick(); end
        idle(); push2_seq(); bus.issue0 = 1; bus.issue1 = 1; tick();
        check("simul_af", {64'd0, bus.almost_full, bus.empty}, 66'd0);
        for (int i = 0; i < 6; i++) begin idle(); bus.issue0 = 1; bus.issue1 = 1; tick(); end
        check("simul_two_left", {64'd0, bus.out_valid1, bus.empty}, {64'd0, 2'b10});
        idle(); bus.issue0 = 1; bus.issue1 = 1; tick();
        check("simul_drained", {65'd0, bus.empty}, {65'd0, 1'b1});

        // issue1 with one entry pops only one; lone in_valid1 and lone issue1 ignored
        idle(); push1(32'h0000_4000, 32'h3333_0000, 0); tick();
        idle(); push1(32'h0000_4004, 32'h3333_0001, 0); bus.issue0 = 1; bus.issue1 = 1; tick();
        check("pop1_of_1", {bus.out_valid0, bus.out_pc0, bus.out_inst0, bus.out_adel0},
              {1'b1, 32'h0000_4004, 32'h3333_0001, 1'b0});
        idle(); bus.in_valid1 = 1; bus.in_pc1 = 32'h0000_5000; bus.issue1 = 1; tick();
        check("lone_v1_issue1", {bus.out_valid0, bus.out_pc0, bus.out_valid1, 32'd0},
              {1'b1, 32'h0000_4004, 1'b0, 32'd0});

        // flush at count 5 with push and issue active
        idle(); push2_seq(); tick();
        idle(); push2_seq(); tick();
        idle(); bus.flush = 1; push1(32'h0000_6000, 32'h4444_0000, 0); bus.issue0 = 1; tick();
        check("flush_state", {64'd0, bus.empty, bus.out_valid0}, {64'd0, 2'b10});
        idle(); tick();

        // asynchronous reset pulse mid-cycle
        idle(); push2_seq(); tick();
        idle(); push1(32'h0000_7000, 32'h5555_0000, 1); tick();
        idle();
        #1 resetn = 0;
        #1;
        check("rst_slot0", {bus.out_valid0, bus.out_pc0, bus.out_inst0, bus.out_adel0}, 66'd0);
        check("rst_slot1", {bus.out_valid1, bus.out_pc1, bus.out_inst1, bus.out_adel1}, 66'd0);
        check("rst_flags", {64'd0, bus.empty, bus.almost_full}, {64'd0, 2'b10});
        #1 resetn = 1;
        tick(); tick();
        check("post_rst_invalid", {65'd0, bus.out_valid0}, 66'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
